pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Per-core program-counter and branch unit, successor to the single-mode NZP PC block. It keeps the NZP flag register and computes `next_pc` once per instruction in the UPDATE stage. It adds width parametrisation, absolute and relative branches, unconditional jumps, and an optional call/return stack with fault reporting. It sits between the decoder/ALU and the fetcher, and is instantiated once per thread lane.

## Interface
Parameters:
- `DATA_BITS`, 8, width of `dec_imm` / `alu_out`
- `PC_BITS`, 8, program-memory address width
- `STACK_DEPTH`, 4, return-stack entries (≥1; only meaningful with `PC_RAS_EN`)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  lane active; when low the block holds all state
- `core_state`  in  3  core pipeline state; UPDATE = 3'b110
- `dec_pc_op`  in  3  PC operation code (see Operation)
- `dec_nzp`  in  3  branch condition mask {N,Z,P}
- `dec_imm`  in  DATA_BITS  branch target or offset
- `nzp_write_en`  in  1  latch `alu_out[2:0]` into the NZP register
- `alu_out`  in  DATA_BITS  ALU result; bits [2:0] hold the NZP flags from compare
- `current_pc`  in  PC_BITS  PC of the executing instruction
- `next_pc`  out  PC_BITS  registered next PC
- `pc_updated`  out  1  one-cycle pulse: `next_pc` was written in the previous cycle
- `branch_taken`  out  1  registered; the last update redirected the PC away from `current_pc + 1`
- `stack_fault`  out  1  sticky; set by a push when full or a pop when empty
- `stack_level`  out  $clog2(STACK_DEPTH+1)  current stack occupancy

## Operation
- The update event is `enable && core_state == UPDATE`. The block changes no state outside an update event.
- Operation codes:
  - 0 SEQ
  - 1 BR_ABS
  - 2 BR_REL
  - 3 JUMP
  - 4 CALL
  - 5 RET
  - 6 and 7 reserved; they behave as SEQ.
- `cond` is true when `(nzp_reg & dec_nzp) != 0`. With `dec_nzp == 0` a conditional branch is never taken.
- `cond` always uses the NZP value held before this event. An `nzp_write_en` in the same event updates `nzp_reg` for the next instruction only.
- `seq` is `current_pc + 1`, computed modulo 2^PC_BITS, so 0xFF wraps to 0x00 for `PC_BITS` = 8.
- Per-operation `next_pc`:
  - SEQ: `seq`.
  - BR_ABS: `cond` ? abs : `seq`. abs is `dec_imm` zero-extended, or truncated, to PC_BITS.
  - BR_REL: `cond` ? `current_pc + sext(dec_imm)` : `seq`. The immediate is sign-extended from DATA_BITS and the sum is taken modulo 2^PC_BITS.
  - JUMP: abs, unconditional.
  - CALL: push `seq`, then `next_pc` = abs. If the stack is full: no push, `stack_fault` set, `next_pc` = `seq`.
  - RET: pop, then `next_pc` = popped value. If the stack is empty: `stack_fault` set, `next_pc` = `seq`.
- `branch_taken` is 1 only when the value written is not `seq` because of a taken or unconditional redirect. A jump whose target equals `seq` still reports 1.
- `stack_fault` clears only on reset.

## Timing
- Every register updates on the rising edge of `clk`.
- Latency is one cycle: `next_pc`, `branch_taken`, `nzp_reg` and the stack all update on the edge that ends the update event.
- `pc_updated` is high for exactly the cycle after the update event. If UPDATE is held for N consecutive enabled cycles, each cycle is an update event and N pulses follow. The core guarantees UPDATE lasts one cycle per instruction.
- Reset values:
  - `next_pc` = 0
  - `nzp_reg` = 0
  - `pc_updated` = 0
  - `branch_taken` = 0
  - `stack_fault` = 0
  - `stack_level` = 0
  - stack contents don't-care
- Reset has priority over everything, including an update event in the same cycle.
- `enable` low in UPDATE counts as no event.

## Configuration
- Macro: `PC_RAS_EN`.
- Defined: the return stack is built and CALL/RET behave as specified above.
- Undefined: no stack storage exists.
  - CALL behaves as JUMP.
  - RET behaves as SEQ, with `branch_taken` = 0.
  - `stack_fault` and `stack_level` are tied to 0.

## Structure
- Package `pc_pkg`:
  - `pc_op_e` enum holding the six operation codes.
  - `CORE_STATE_UPDATE` = 3'b110.
  - NZP bit-index constants.
- Sub-module `return_stack`: a parametrised LIFO.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`.
  - Built only under `PC_RAS_EN`.

## Test plan
- Reset, then SEQ updates with `current_pc` = 0xFF, `PC_BITS` = 8 -> `next_pc` = 0x00, `branch_taken` = 0, one `pc_updated` pulse per update.
- `alu_out` = 3'b010 with `nzp_write_en`, then BR_ABS with `dec_nzp` = 3'b010 and `dec_imm` = 0x20 -> taken, `next_pc` = 0x20. The same branch with `dec_nzp` = 3'b101 -> `current_pc + 1`.
- BR_REL with `dec_imm` = 0xFC, `current_pc` = 0x02, condition true -> `next_pc` = 0xFE, showing sign-extended wrap.
- An NZP write and a conditional branch in the same event -> the branch uses the previous flags, and the new flags govern the next branch.
- With `PC_RAS_EN`, `STACK_DEPTH` = 2: CALL at 0x10 and 0x30 -> level 2. A third CALL -> `stack_fault` = 1, `next_pc` = `seq`. RET -> 0x31. RET -> 0x11. A third RET -> fault stays 1, `next_pc` = `current_pc + 1`.
- UPDATE with `enable` = 0, and reset asserted during an update event -> no state change, or reset values respectively. Without `PC_RAS_EN`, CALL to 0x40 -> `next_pc` = 0x40 and `stack_level` = 0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: definitions shared by the program-counter / branch unit.
//   pc_op_e           - PC operation codes driven by the decoder (6, 7 reserved)
//   CORE_STATE_UPDATE - core pipeline state in which next_pc is computed
//   NZP_*_BIT         - bit positions of the N, Z, P flags in the NZP register
package pc_pkg;

    typedef enum logic [2:0] {
        PC_OP_SEQ    = 3'd0,
        PC_OP_BR_ABS = 3'd1,
        PC_OP_BR_REL = 3'd2,
        PC_OP_JUMP   = 3'd3,
        PC_OP_CALL   = 3'd4,
        PC_OP_RET    = 3'd5
    } pc_op_e;

    localparam logic [2:0] CORE_STATE_UPDATE = 3'b110;

    localparam int NZP_P_BIT = 0;
    localparam int NZP_Z_BIT = 1;
    localparam int NZP_N_BIT = 2;

endpackage

// File: rtl/pc_branch_unit_return_stack.sv
// return_stack: parametrised LIFO holding return addresses for CALL/RET.
// Only compiled when PC_RAS_EN is defined.
//   clk, reset     - clock, synchronous active-high reset (clears occupancy)
//   push, din      - write din on top of the stack (ignored when full)
//   pop            - discard the top entry (ignored when empty)
//   dout           - current top entry, valid while not empty
//   full, empty    - occupancy flags
//   level          - number of valid entries, 0..DEPTH
`ifdef PC_RAS_EN
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    // Storage is rounded up to a power of two so the index width matches
    // the array exactly; entries beyond DEPTH are never addressed.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [0:(1<<IDX_W)-1];
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = IDX_W'(level_q);
    assign rd_idx  = IDX_W'(level_q - LVL_W'(1));
    assign dout    = mem_q[rd_idx];
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        if (do_push) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule
`endif

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: per-lane program counter and branch unit.
// Holds the NZP flag register and computes next_pc once per instruction
// during the UPDATE core state (enable && core_state == CORE_STATE_UPDATE).
// Optional feature macro: PC_RAS_EN builds the return-address stack for
// CALL/RET; without it CALL acts as JUMP, RET as SEQ, and the stack
// outputs are tied to 0.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   enable, core_state   - lane active / pipeline state
//   dec_pc_op, dec_nzp   - operation code and branch condition mask {N,Z,P}
//   dec_imm              - absolute target or signed relative offset
//   nzp_write_en,alu_out - latch alu_out[2:0] into the NZP register
//   current_pc           - PC of the executing instruction
//   next_pc              - registered next PC
//   pc_updated           - pulse in the cycle after each update event
//   branch_taken         - last update redirected away from current_pc + 1
//   stack_fault          - sticky overflow/underflow flag
//   stack_level          - return stack occupancy
module pc_branch_unit
    import pc_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PC_BITS     = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [2:0]                         core_state,
    input  logic [2:0]                         dec_pc_op,
    input  logic [2:0]                         dec_nzp,
    input  logic [DATA_BITS-1:0]               dec_imm,
    input  logic                               nzp_write_en,
    input  logic [DATA_BITS-1:0]               alu_out,
    input  logic [PC_BITS-1:0]                 current_pc,
    output logic [PC_BITS-1:0]                 next_pc,
    output logic                               pc_updated,
    output logic                               branch_taken,
    output logic                               stack_fault,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic               update_ev;
    logic [PC_BITS-1:0] seq_pc;
    logic [PC_BITS-1:0] abs_pc;
    logic [PC_BITS-1:0] rel_off;
    logic [PC_BITS-1:0] rel_pc;
    logic               cond;

    logic [2:0]         nzp_q;
    logic [PC_BITS-1:0] next_pc_q;
    logic [PC_BITS-1:0] next_pc_d;
    logic               taken_q;
    logic               taken_d;
    logic               pc_updated_q;

    // Only the flag bits of the ALU result are of interest here.
    logic unused_alu_hi;
    assign unused_alu_hi = ^alu_out[DATA_BITS-1:3];

    assign update_ev = enable && (core_state == CORE_STATE_UPDATE);
    assign seq_pc    = current_pc + PC_BITS'(1);

    // Immediate fitted to PC width: truncate when wider, otherwise
    // zero-extend for absolute targets and sign-extend for offsets.
    generate
        if (DATA_BITS >= PC_BITS) begin : g_imm_trunc
            assign abs_pc  = dec_imm[PC_BITS-1:0];
            assign rel_off = dec_imm[PC_BITS-1:0];
            if (DATA_BITS > PC_BITS) begin : g_imm_hi
                logic unused_imm_hi;
                assign unused_imm_hi = ^dec_imm[DATA_BITS-1:PC_BITS];
            end
        end else begin : g_imm_ext
            assign abs_pc  = {{(PC_BITS-DATA_BITS){1'b0}}, dec_imm};
            assign rel_off = {{(PC_BITS-DATA_BITS){dec_imm[DATA_BITS-1]}}, dec_imm};
        end
    endgenerate

    assign rel_pc = current_pc + rel_off;

    // Condition always evaluates the flags held before this event.
    assign cond = (nzp_q[NZP_N_BIT] & dec_nzp[NZP_N_BIT])
                | (nzp_q[NZP_Z_BIT] & dec_nzp[NZP_Z_BIT])
                | (nzp_q[NZP_P_BIT] & dec_nzp[NZP_P_BIT]);

`ifdef PC_RAS_EN
    logic               stk_push;
    logic               stk_pop;
    logic               stk_full;
    logic               stk_empty;
    logic [PC_BITS-1:0] stk_dout;
    logic [LVL_W-1:0]   stk_level;
    logic               fault_set;
    logic               stack_fault_q;

    return_stack #(
        .WIDTH (PC_BITS),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (seq_pc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .level (stk_level)
    );
`endif

    always_comb begin
        next_pc_d = seq_pc;
        taken_d   = 1'b0;
`ifdef PC_RAS_EN
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        fault_set = 1'b0;
`endif
        case (dec_pc_op)
            PC_OP_BR_ABS: begin
                if (cond) begin
                    next_pc_d = abs_pc;
                    taken_d   = 1'b1;
                end
            end
            PC_OP_BR_REL: begin
                if (cond) begin
                    next_pc_d = rel_pc;
                    taken_d   = 1'b1;
                end
            end
            PC_OP_JUMP: begin
                next_pc_d = abs_pc;
                taken_d   = 1'b1;
            end
`ifdef PC_RAS_EN
            // A faulting CALL/RET falls through to sequential flow.
            PC_OP_CALL: begin
                if (stk_full) begin
                    fault_set = 1'b1;
                end else begin
                    stk_push  = update_ev;
                    next_pc_d = abs_pc;
                    taken_d   = 1'b1;
                end
            end
            PC_OP_RET: begin
                if (stk_empty) begin
                    fault_set = 1'b1;
                end else begin
                    stk_pop   = update_ev;
                    next_pc_d = stk_dout;
                    taken_d   = 1'b1;
                end
            end
`else
            PC_OP_CALL: begin
                next_pc_d = abs_pc;
                taken_d   = 1'b1;
            end
`endif
            default: begin
                // SEQ, RET without a stack, and reserved codes.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nzp_q        <= 3'b000;
            next_pc_q    <= '0;
            taken_q      <= 1'b0;
            pc_updated_q <= 1'b0;
        end else begin
            pc_updated_q <= update_ev;
            if (update_ev) begin
                next_pc_q <= next_pc_d;
                taken_q   <= taken_d;
                if (nzp_write_en) begin
                    nzp_q <= alu_out[2:0];
                end
            end
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stack_fault_q <= 1'b0;
        end else if (update_ev && fault_set) begin
            stack_fault_q <= 1'b1;
        end
    end

    assign stack_fault = stack_fault_q;
    assign stack_level = stk_level;
`else
    assign stack_fault = 1'b0;
    assign stack_level = '0;
`endif

    assign next_pc      = next_pc_q;
    assign branch_taken = taken_q;
    assign pc_updated   = pc_updated_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit (DATA_BITS = PC_BITS = 8,
// STACK_DEPTH = 2). Stack-specific scenarios depend on PC_RAS_EN.
module tb_pc_branch_unit;

    localparam int DB = 8;
    localparam int PB = 8;
    localparam int SD = 2;
    localparam int LW = $clog2(SD + 1);
    localparam int M  = 1 << PB;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [2:0]    core_state;
    logic [2:0]    dec_pc_op;
    logic [2:0]    dec_nzp;
    logic [DB-1:0] dec_imm;
    logic          nzp_write_en;
    logic [DB-1:0] alu_out;
    logic [PB-1:0] current_pc;
    logic [PB-1:0] next_pc;
    logic          pc_updated;
    logic          branch_taken;
    logic          stack_fault;
    logic [LW-1:0] stack_level;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_next, m_taken, m_fault, m_upd, m_nzp;
    int m_stk[$];

    pc_branch_unit #(
        .DATA_BITS   (DB),
        .PC_BITS     (PB),
        .STACK_DEPTH (SD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .core_state   (core_state),
        .dec_pc_op    (dec_pc_op),
        .dec_nzp      (dec_nzp),
        .dec_imm      (dec_imm),
        .nzp_write_en (nzp_write_en),
        .alu_out      (alu_out),
        .current_pc   (current_pc),
        .next_pc      (next_pc),
        .pc_updated   (pc_updated),
        .branch_taken (branch_taken),
        .stack_fault  (stack_fault),
        .stack_level  (stack_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_next = 0; m_taken = 0; m_fault = 0; m_upd = 0; m_nzp = 0;
        m_stk.delete();
    endtask

    // Behaviour of one update event, from the operation rules.
    task automatic model_event(input int op, input int nzp, input int imm,
                               input int we, input int alu, input int pc);
        int seq, absv, simm, relv, cond;
        seq  = (pc + 1) % M;
        absv = imm % M;
        simm = (imm >= (1 << (DB - 1))) ? imm - (1 << DB) : imm;
        relv = (((pc + simm) % M) + M) % M;
        cond = ((m_nzp & nzp) != 0) ? 1 : 0;
        m_next = seq; m_taken = 0;
        case (op)
            1: if (cond != 0) begin m_next = absv; m_taken = 1; end
            2: if (cond != 0) begin m_next = relv; m_taken = 1; end
            3: begin m_next = absv; m_taken = 1; end
`ifdef PC_RAS_EN
            4: if (m_stk.size() == SD) m_fault = 1;
               else begin m_stk.push_back(seq); m_next = absv; m_taken = 1; end
            5: if (m_stk.size() == 0) m_fault = 1;
               else begin m_next = m_stk.pop_back(); m_taken = 1; end
`else
            4: begin m_next = absv; m_taken = 1; end
`endif
            default: ;
        endcase
        if (we != 0) m_nzp = alu % 8;
    endtask

    // Presents one instruction for one cycle; returns #1 after the edge.
    task automatic upd(input int op, input int nzp, input int imm, input int we,
                       input int alu, input int pc, input int en, input int st);
        dec_pc_op    = op[2:0];
        dec_nzp      = nzp[2:0];
        dec_imm      = imm[DB-1:0];
        nzp_write_en = we[0];
        alu_out      = alu[DB-1:0];
        current_pc   = pc[PB-1:0];
        enable       = en[0];
        core_state   = st[2:0];
        @(posedge clk);
        m_upd = (en != 0 && st == 6) ? 1 : 0;
        if (m_upd != 0) model_event(op, nzp, imm, we, alu, pc);
        #1;
        core_state   = 3'd0;
        enable       = 1'b1;
        nzp_write_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        // Reset asserted together with an update event must win.
        reset = 1'b1; enable = 1'b1; core_state = 3'b110;
        dec_pc_op = 3'd3; dec_imm = 8'h99; current_pc = 8'h10;
        nzp_write_en = 1'b1; alu_out = 8'h07;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (next_pc !== 8'h00) begin n_err++; $display("FAIL reset next_pc: got %h want 00", next_pc); end
        n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL reset branch_taken: got %b want 0", branch_taken); end
        n_vec++; if (pc_updated !== 1'b0) begin n_err++; $display("FAIL reset pc_updated: got %b want 0", pc_updated); end
        n_vec++; if (stack_fault !== 1'b0) begin n_err++; $display("FAIL reset stack_fault: got %b want 0", stack_fault); end
        n_vec++; if (stack_level !== '0) begin n_err++; $display("FAIL reset stack_level: got %0d want 0", stack_level); end
        reset = 1'b0; core_state = 3'd0; nzp_write_en = 1'b0;
        model_reset();
        // NZP was cleared: any conditional branch falls through.
        upd(1, 7, 8'h33, 0, 0, 8'h05, 1, 6);
        n_vec++; if (next_pc !== 8'h06) begin n_err++; $display("FAIL reset_nzp next_pc: got %h want 06", next_pc); end
        n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL reset_nzp branch_taken: got %b want 0", branch_taken); end
    endtask

    task automatic test_seq_wrap();
        for (int i = 0; i < 3; i++) begin
            upd(0, 0, 0, 0, 0, 8'hFF, 1, 6);
            n_vec++; if (next_pc !== 8'h00) begin n_err++; $display("FAIL seq_wrap next_pc: got %h want 00", next_pc); end
            n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL seq_wrap branch_taken: got %b want 0", branch_taken); end
            n_vec++; if (pc_updated !== 1'b1) begin n_err++; $display("FAIL seq_wrap pc_updated: got %b want 1", pc_updated); end
        end
        @(posedge clk); #1;
        n_vec++; if (pc_updated !== 1'b0) begin n_err++; $display("FAIL seq_wrap pulse_end: got %b want 0", pc_updated); end
    endtask

    task automatic test_br_abs();
        upd(0, 0, 0, 1, 8'h02, 8'h00, 1, 6);
        upd(1, 3'b010, 8'h20, 0, 0, 8'h07, 1, 6);
        n_vec++; if (next_pc !== 8'h20) begin n_err++; $display("FAIL br_abs_taken next_pc: got %h want 20", next_pc); end
        n_vec++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL br_abs_taken branch_taken: got %b want 1", branch_taken); end
        upd(1, 3'b101, 8'h20, 0, 0, 8'h07, 1, 6);
        n_vec++; if (next_pc !== 8'h08) begin n_err++; $display("FAIL br_abs_not next_pc: got %h want 08", next_pc); end
        n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL br_abs_not branch_taken: got %b want 0", branch_taken); end
        // Unconditional jump to seq still reports a redirect.
        upd(3, 0, 8'h08, 0, 0, 8'h07, 1, 6);
        n_vec++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL jump_to_seq branch_taken: got %b want 1", branch_taken); end
    endtask

    task automatic test_br_rel();
        upd(0, 0, 0, 1, 8'h01, 8'h00, 1, 6);
        upd(2, 3'b001, 8'hFC, 0, 0, 8'h02, 1, 6);
        n_vec++; if (next_pc !== 8'hFE) begin n_err++; $display("FAIL br_rel next_pc: got %h want FE", next_pc); end
        n_vec++; if (branch_taken !== 1'b1) begin n_err++; $display("FAIL br_rel branch_taken: got %b want 1", branch_taken); end
    endtask

    task automatic test_nzp_same_event();
        upd(0, 0, 0, 1, 8'h01, 8'h00, 1, 6);        // flags = P
        upd(1, 3'b010, 8'h44, 1, 8'h02, 8'h10, 1, 6); // tests Z with old flags, writes Z
        n_vec++; if (next_pc !== 8'h11) begin n_err++; $display("FAIL nzp_same_old next_pc: got %h want 11", next_pc); end
        upd(1, 3'b010, 8'h44, 0, 0, 8'h11, 1, 6);
        n_vec++; if (next_pc !== 8'h44) begin n_err++; $display("FAIL nzp_same_new next_pc: got %h want 44", next_pc); end
    endtask

`ifdef PC_RAS_EN
    task automatic test_stack();
        do_reset();
        upd(4, 0, 8'h50, 0, 0, 8'h10, 1, 6);
        upd(4, 0, 8'h60, 0, 0, 8'h30, 1, 6);
        n_vec++; if (stack_level !== 2'd2) begin n_err++; $display("FAIL stack_two_calls level: got %0d want 2", stack_level); end
        n_vec++; if (next_pc !== 8'h60) begin n_err++; $display("FAIL stack_two_calls next_pc: got %h want 60", next_pc); end
        upd(4, 0, 8'h80, 0, 0, 8'h70, 1, 6);
        n_vec++; if (stack_fault !== 1'b1) begin n_err++; $display("FAIL stack_overflow fault: got %b want 1", stack_fault); end
        n_vec++; if (next_pc !== 8'h71) begin n_err++; $display("FAIL stack_overflow next_pc: got %h want 71", next_pc); end
        n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL stack_overflow branch_taken: got %b want 0", branch_taken); end
        upd(5, 0, 0, 0, 0, 8'h99, 1, 6);
        n_vec++; if (next_pc !== 8'h31) begin n_err++; $display("FAIL stack_ret1 next_pc: got %h want 31", next_pc); end
        upd(5, 0, 0, 0, 0, 8'h99, 1, 6);
        n_vec++; if (next_pc !== 8'h11) begin n_err++; $display("FAIL stack_ret2 next_pc: got %h want 11", next_pc); end
        n_vec++; if (stack_level !== 2'd0) begin n_err++; $display("FAIL stack_ret2 level: got %0d want 0", stack_level); end
        upd(5, 0, 0, 0, 0, 8'h40, 1, 6);
        n_vec++; if (next_pc !== 8'h41) begin n_err++; $display("FAIL stack_underflow next_pc: got %h want 41", next_pc); end
        n_vec++; if (stack_fault !== 1'b1) begin n_err++; $display("FAIL stack_underflow fault: got %b want 1", stack_fault); end
        do_reset();
        n_vec++; if (stack_fault !== 1'b0) begin n_err++; $display("FAIL stack_fault_reset: got %b want 0", stack_fault); end
    endtask
`else
    task automatic test_call_no_ras();
        upd(4, 0, 8'h40, 0, 0, 8'h10, 1, 6);
        n_vec++; if (next_pc !== 8'h40) begin n_err++; $display("FAIL call_as_jump next_pc: got %h want 40", next_pc); end
        n_vec++; if (stack_level !== '0) begin n_err++; $display("FAIL call_as_jump level: got %0d want 0", stack_level); end
        upd(5, 0, 8'h40, 0, 0, 8'h20, 1, 6);
        n_vec++; if (next_pc !== 8'h21) begin n_err++; $display("FAIL ret_as_seq next_pc: got %h want 21", next_pc); end
        n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL ret_as_seq branch_taken: got %b want 0", branch_taken); end
        n_vec++; if (stack_fault !== 1'b0) begin n_err++; $display("FAIL ret_as_seq fault: got %b want 0", stack_fault); end
    endtask
`endif

    task automatic test_enable_low();
        upd(3, 0, 8'h5A, 1, 8'h02, 8'h00, 1, 6);     // next = 5A, flags = Z
        upd(3, 0, 8'hA5, 1, 8'h07, 8'h00, 0, 6);     // disabled: nothing changes
        n_vec++; if (next_pc !== 8'h5A) begin n_err++; $display("FAIL en_low next_pc: got %h want 5A", next_pc); end
        n_vec++; if (pc_updated !== 1'b0) begin n_err++; $display("FAIL en_low pc_updated: got %b want 0", pc_updated); end
        upd(1, 3'b101, 8'h77, 0, 0, 8'h30, 1, 6);    // flags still Z only
        n_vec++; if (next_pc !== 8'h31) begin n_err++; $display("FAIL en_low_nzp next_pc: got %h want 31", next_pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int st;
            st = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : 6;
            upd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
                ($urandom_range(0, 9) != 0) ? 1 : 0, st);
            n_vec++; if (next_pc !== PB'(m_next)) begin n_err++; $display("FAIL rand[%0d] next_pc: got %h want %h", i, next_pc, PB'(m_next)); end
            n_vec++; if (branch_taken !== m_taken[0]) begin n_err++; $display("FAIL rand[%0d] branch_taken: got %b want %b", i, branch_taken, m_taken[0]); end
            n_vec++; if (pc_updated !== m_upd[0]) begin n_err++; $display("FAIL rand[%0d] pc_updated: got %b want %b", i, pc_updated, m_upd[0]); end
`ifdef PC_RAS_EN
            n_vec++; if (stack_fault !== m_fault[0]) begin n_err++; $display("FAIL rand[%0d] stack_fault: got %b want %b", i, stack_fault, m_fault[0]); end
            n_vec++; if (stack_level !== LW'(m_stk.size())) begin n_err++; $display("FAIL rand[%0d] stack_level: got %0d want %0d", i, stack_level, m_stk.size()); end
`else
            n_vec++; if (stack_fault !== 1'b0) begin n_err++; $display("FAIL rand[%0d] stack_fault: got %b want 0", i, stack_fault); end
            n_vec++; if (stack_level !== '0) begin n_err++; $display("FAIL rand[%0d] stack_level: got %0d want 0", i, stack_level); end
`endif
        end
    endtask

    task automatic test_reset_during_update();
        upd(3, 0, 8'h77, 0, 0, 8'h00, 1, 6);
        reset = 1'b1; enable = 1'b1; core_state = 3'b110;
        dec_pc_op = 3'd3; dec_imm = 8'h55;
        @(posedge clk); #1;
        n_vec++; if (next_pc !== 8'h00) begin n_err++; $display("FAIL rst_upd next_pc: got %h want 00", next_pc); end
        n_vec++; if (branch_taken !== 1'b0) begin n_err++; $display("FAIL rst_upd branch_taken: got %b want 0", branch_taken); end
        n_vec++; if (pc_updated !== 1'b0) begin n_err++; $display("FAIL rst_upd pc_updated: got %b want 0", pc_updated); end
        reset = 1'b0; core_state = 3'd0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = 3'd0; dec_pc_op = 3'd0;
        dec_nzp = 3'd0; dec_imm = '0; nzp_write_en = 1'b0; alu_out = '0;
        current_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_seq_wrap();
        test_br_abs();
        test_br_rel();
        test_nzp_same_event();
`ifdef PC_RAS_EN
        test_stack();
`else
        test_call_no_ras();
`endif
        test_enable_low();
        test_random();
        test_reset_during_update();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
